// File: rtl/mem_bus_master.sv
// Single-initiator master for the simple memory bus: one command in, one bus
// transaction out, one response back. Optional abort timer: MEM_BUS_MASTER_TIMEOUT_EN.
module mem_bus_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the sender holds valid and payload stable until that edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Exposed for checkers bound onto this module.
    state_t state;
    state_t state_next;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic cmd_take;
    logic bus_done;
    logic bus_abort;
    logic rsp_take;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_valid)             state_next = ST_BUS;
            ST_BUS:  if (mem_ready || bus_abort) state_next = ST_RESP;
            ST_RESP: if (rsp_ready)             state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        cmd_take  = (state == ST_IDLE) && cmd_valid;
        bus_done  = (state == ST_BUS) && mem_ready;
        rsp_take  = (state == ST_RESP) && rsp_ready;
    end

    // Bus side: request fields are zeroed whenever no transaction is in flight.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (cmd_take) begin
            mem_valid <= 1'b1;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
            mem_wstrb <= cmd_wstrb;
        end else if (bus_done || bus_abort) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end
    end

    // Response side: read data is captured only in the completing cycle of a read.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (bus_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (mem_wstrb == 4'b0000) ? mem_rdata : 32'd0;
        end else if (bus_abort) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
        end
    end

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        rsp_err_q;

    // Counts BUS cycles without mem_ready; aborts at the end of the last allowed one.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 16'd0;
        end else if (cmd_take) begin
            tmo_cnt <= 16'd0;
        end else if ((state == ST_BUS) && !mem_ready) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign bus_abort = (state == ST_BUS) && !mem_ready && (tmo_cnt == TMO_LAST);

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (bus_done) begin
            rsp_err_q <= 1'b0;
        end else if (bus_abort) begin
            rsp_err_q <= 1'b1;
        end else if (rsp_take) begin
            rsp_err_q <= 1'b0;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_tmo;

    assign unused_tmo = ^TMO_LAST;
    assign bus_abort  = 1'b0;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_bus_master;

    localparam int TMO = 8;
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        mem_clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .mem_clk   (mem_clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- responder ----------------
    int          wait_target = 0;
    int          wait_cnt = 0;
    logic [31:0] cur_rdata = 32'd0;

    assign mem_ready = mem_valid && (wait_cnt == wait_target);
    assign mem_rdata = mem_ready ? cur_rdata : 32'hDEAD_BEEF;

    always @(posedge mem_clk) begin
        wait_cnt <= (mem_valid && !mem_ready) ? wait_cnt + 1 : 0;
    end

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];

    bit          m_bus, m_rsp, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    int          m_cyc;

    always @(negedge mem_clk) begin
        if (!rst_n) begin
            check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
            check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            m_bus = 0; m_rsp = 0; m_err = 0; m_cyc = 0;
        end else begin
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, !(m_bus || m_rsp)});
            check("mem_valid", {31'd0, mem_valid}, {31'd0, m_bus});
            check("mem_addr",  mem_addr,  m_bus ? m_addr : 32'd0);
            check("mem_wdata", mem_wdata, m_bus ? m_wdata : 32'd0);
            check("mem_wstrb", {28'd0, mem_wstrb}, m_bus ? {28'd0, m_wstrb} : 32'd0);
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp});
            check("rsp_rdata", rsp_rdata, m_rsp ? m_rdata : 32'd0);
            check("rsp_err",   {31'd0, rsp_err}, {31'd0, m_rsp && m_err});
            if (!m_bus && !m_rsp) begin
                if (cmd_valid) begin
                    m_bus = 1; m_cyc = 0;
                    m_addr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
                end
            end else if (m_bus) begin
                if (m_cyc == wait_target) begin
                    m_bus = 0; m_rsp = 1; m_err = 0;
                    m_rdata = (m_wstrb == 4'd0) ? cur_rdata : 32'd0;
                end else if (TMO_EN && m_cyc == TMO - 1) begin
                    m_bus = 0; m_rsp = 1; m_err = 1; m_rdata = 32'd0;
                end else begin
                    m_cyc++;
                end
            end else if (rsp_ready) begin
                m_rsp = 0;
                if (exp_q.size() == 0) check("rsp_unexpected", rsp_rdata, 32'hFFFF_FFFF);
                else check("rsp_order", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Observed pulse lengths and rise times of mem_valid, for literal checks.
    int cyc = 0;
    int mv_run = 0;
    int last_mv_len = 0;
    int rise_q[$];
    bit prev_mv = 0;

    always @(negedge mem_clk) begin
        cyc++;
        if (mem_valid) begin
            if (!prev_mv) rise_q.push_back(cyc);
            mv_run++;
        end else if (mv_run > 0) begin
            last_mv_len = mv_run;
            mv_run = 0;
        end
        prev_mv = mem_valid;
    end

    // ---------------- driver tasks ----------------
    bit rand_rr = 0;

    task automatic tick();
        @(posedge mem_clk);
        #1;
        if (rand_rr) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic stage_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             input logic [31:0] rd, input int waits);
        cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        cur_rdata = rd; wait_target = waits;
        if (TMO_EN && waits >= TMO) exp_q.push_back(32'd0);
        else exp_q.push_back((ws == 4'd0) ? rd : 32'd0);
        cmd_valid = 1'b1;
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] rd, input int waits, input bit hold);
        int n;
        bit acc;
        n = 0;
        while (mem_valid && n < 200) begin tick(); n++; end
        if (n >= 200) check("bus_free_timeout", 32'd0, 32'd1);
        stage_cmd(a, wd, ws, rd, waits);
        n = 0; acc = 0;
        while (!acc && n < 200) begin acc = cmd_ready; tick(); n++; end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        while (!rsp_valid && n < 300) begin tick(); n++; end
        if (n >= 300) check("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_rdata; er = rsp_err;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(cmd_ready && !rsp_valid) && n < 300) begin tick(); n++; end
        if (n >= 300) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          pulses;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge mem_clk);
        #1;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write completing in the first bus cycle.
        do_cmd(32'h5, 32'h0000_00FF, 4'hF, 32'h1357_9BDF, 0, 0);
        check("wr_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("wr_mem_addr", mem_addr, 32'h5);
        check("wr_mem_wdata", mem_wdata, 32'hFF);
        wait_rsp(rd, er);
        check("wr_rsp_rdata", rd, 32'd0);
        check("wr_rsp_err", {31'd0, er}, 32'd0);
        check("wr_mv_len", last_mv_len, 32'd1);
        drain();

        // Read with three wait states.
        do_cmd(32'h4, 32'd0, 4'h0, 32'hA5, 3, 0);
        wait_rsp(rd, er);
        check("rd_rsp_rdata", rd, 32'h0000_00A5);
        check("rd_rsp_err", {31'd0, er}, 32'd0);
        check("rd_mv_len", last_mv_len, 32'd4);
        drain();

        // Response back-pressure with cmd_valid held high.
        rsp_ready = 1'b0;
        do_cmd(32'h10, 32'd0, 4'h0, 32'h1234, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1234);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_mem_valid", {31'd0, mem_valid}, 32'd0);
            tick();
        end
        stage_cmd(32'h44, 32'hCAFE_F00D, 4'h3, 32'd0, 0);
        rsp_ready = 1'b1;
        tick();
        check("bp_after_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("bp_next_mem_addr", mem_addr, 32'h44);
        drain();

        // Back-to-back writes.
        rise_q.delete();
        for (int i = 1; i <= 3; i++) do_cmd(32'(i), 32'(i * 16), 4'hF, 32'd0, 0, 0);
        drain();
        check("b2b_rises", rise_q.size(), 32'd3);
        if (rise_q.size() == 3) begin
            check("b2b_gap1", rise_q[1] - rise_q[0], 32'd3);
            check("b2b_gap2", rise_q[2] - rise_q[1], 32'd3);
        end
        check("b2b_mv_len", last_mv_len, 32'd1);

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
        do_cmd(32'h20, 32'd0, 4'h0, 32'h77, 1000, 0);
        wait_rsp(rd, er);
        check("tmo_rsp_err", {31'd0, er}, 32'd1);
        check("tmo_rsp_rdata", rd, 32'd0);
        check("tmo_mv_len", last_mv_len, 32'd8);
        drain();
        do_cmd(32'h24, 32'd0, 4'h0, 32'h77, 7, 0);
        wait_rsp(rd, er);
        check("tmo_edge_err", {31'd0, er}, 32'd0);
        check("tmo_edge_rdata", rd, 32'h77);
        check("tmo_edge_mv_len", last_mv_len, 32'd8);
        drain();
`endif

        // Reset while a transaction is on the bus.
        do_cmd(32'h30, 32'd0, 4'h0, 32'h99, 50, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstbus_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rstbus_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        check("rstbus_no_rsp", pulses, 32'd0);
        check("rstbus_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Randomized traffic with random response back-pressure.
        rand_rr = 1;
        for (int i = 0; i < 60; i++) begin
            do_cmd($urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                   $urandom, $urandom_range(0, 4), 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rr = 0;
        rsp_ready = 1'b1;
        drain();
        tick();
        check("final_exp_q_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got %0d expected finish", n_cmp);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
